// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the control FSM (master) and the
// data-memory stage (slave).
//   mem_req, mem_wr, size, load_unsigned, addr, write_data : master -> slave
//   read_data, mem_ready, busy, misalign                   : slave -> master
interface dmem_if;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        busy;
  logic        misalign;

  modport master (
    output mem_req, mem_wr, size, load_unsigned, addr, write_data,
    input  read_data, mem_ready, busy, misalign
  );

  modport slave (
    input  mem_req, mem_wr, size, load_unsigned, addr, write_data,
    output read_data, mem_ready, busy, misalign
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory stage with a configurable wait-state
// byte-addressed memory, little-endian, byte/half/word accesses.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   bus   : dmem_if.slave (request capture, extended load data, ready pulse,
//           busy, misalign)
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses flag misalign, skip the store
//               and return read_data = 0
//   undefined : misalign is tied low, low address bits are forced to alignment
//
// state | meaning
// IDLE  | waiting for mem_req
// WAIT  | counting down wait states; access happens when the counter is 0
// DONE  | one-cycle mem_ready pulse, then back to IDLE
module dmem_ctrl #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            access;

  logic            cap_wr;
  logic            cap_uns;
  logic [1:0]      cap_size;
  logic [AW-1:0]   cap_addr;
  logic [31:0]     cap_wd;

  logic [7:0]      mem [DEPTH_BYTES];
  logic [31:0]     rd_q;

  logic            is_half;
  logic            is_word;
  logic            fault;
  logic [AW-1:0]   a0, a1, a2, a3;
  logic [7:0]      b0, b1, b2, b3;
  logic [31:0]     ld_val;

  assign is_half = (cap_size == 2'b01);
  assign is_word = cap_size[1];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic mis_q;

  assign fault = (is_half & cap_addr[0]) | (is_word & (cap_addr[1:0] != 2'b00));
  assign a0    = cap_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (access) begin
      mis_q <= fault;
    end else if (state == DONE) begin
      mis_q <= 1'b0;
    end
  end

  assign bus.misalign = mis_q;
`else
  assign fault = 1'b0;
  // Force natural alignment so an access never straddles a word.
  assign a0 = {cap_addr[AW-1:2],
               is_word ? 2'b00 : {cap_addr[1], is_half ? 1'b0 : cap_addr[0]}};
  assign bus.misalign = 1'b0;
`endif

  // AW-bit arithmetic wraps at DEPTH_BYTES.
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    ld_val = {b3, b2, b1, b0};
    case (cap_size)
      2'b00:   ld_val = cap_uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   ld_val = cap_uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: ld_val = {b3, b2, b1, b0};
    endcase
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (bus.mem_req) state_nxt = WAIT;
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_wr   <= 1'b0;
      cap_uns  <= 1'b0;
      cap_size <= 2'b00;
      cap_addr <= '0;
      cap_wd   <= 32'h0;
      rd_q     <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.mem_req) begin
        cnt      <= 4'(LATENCY);
        cap_wr   <= bus.mem_wr;
        cap_uns  <= bus.load_unsigned;
        cap_size <= bus.size;
        cap_addr <= bus.addr[AW-1:0];
        cap_wd   <= bus.write_data;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && fault) begin
        rd_q <= 32'h0;
      end else if (access && !cap_wr) begin
        rd_q <= ld_val;
      end
    end
  end

  // Writes are gated by state, which reset forces to IDLE, so an aborted
  // store never reaches the array.
  always_ff @(posedge clk) begin
    if (access && cap_wr && !fault) begin
      mem[a0] <= cap_wd[7:0];
      if (is_half || is_word) mem[a1] <= cap_wd[15:8];
      if (is_word) begin
        mem[a2] <= cap_wd[23:16];
        mem[a3] <= cap_wd[31:24];
      end
    end
  end

  assign bus.read_data = rd_q;
  assign bus.mem_ready = (state == DONE);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dmem_if bus ();

  dmem_ctrl #(.DEPTH_BYTES(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, checks the ready latency, returns read_data and
  // misalign as seen in the DONE cycle, and leaves the DUT back in IDLE.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] rd, output logic mis);
    int lat;
    @(negedge clk);
    bus.mem_req       = 1'b1;
    bus.mem_wr        = wr;
    bus.size          = sz;
    bus.load_unsigned = uns;
    bus.addr          = ad;
    bus.write_data    = wd;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    rd  = bus.read_data;
    mis = bus.misalign;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        mis;
  int          pulses;
  int          idles;
  int          pe[3];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_wr = 1'b0;
    bus.size = 2'b00;
    bus.load_unsigned = 1'b0;
    bus.addr = 32'h0;
    bus.write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", bus.read_data, 32'h0);
    check("rst_ready", 32'(bus.mem_ready), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_mis", 32'(bus.misalign), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis);
    check("st_w10_rd", rd, 32'h0);
    check("st_w10_mis", 32'(mis), 32'h0);
    check("idle_busy", 32'(bus.busy), 32'h0);
    run_req("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis);
    check("ld_w10", rd, 32'hDEADBEEF);
    run_req("ld_b13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, mis);
    check("ld_b13s", rd, 32'hFFFFFFDE);
    run_req("ld_b13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, mis);
    check("ld_b13u", rd, 32'h000000DE);
    run_req("ld_h10s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, mis);
    check("ld_h10s", rd, 32'hFFFFBEEF);
    run_req("ld_h12u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, mis);
    check("ld_h12u", rd, 32'h0000DEAD);
    run_req("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345678, rd, mis);
    check("st_b11_rd_kept", rd, 32'h0000DEAD);
    run_req("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis);
    check("ld_w10_after_b", rd, 32'hDEAD78EF);
    run_req("ld_sz11", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, rd, mis);
    check("ld_sz11", rd, 32'hDEAD78EF);

    // mem_req held high: requests sampled at edges 0, 5, 10.
    @(negedge clk);
    bus.mem_req = 1'b1;
    bus.mem_wr = 1'b0;
    bus.size = 2'b10;
    bus.addr = 32'h10;
    @(posedge clk);
    pulses = 0;
    idles = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready === 1'b1) begin
        if (pulses < 3) pe[pulses] = k;
        pulses++;
      end
      if (bus.busy === 1'b0) idles++;
    end
    @(negedge clk);
    bus.mem_req = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_first", 32'(pe[0]), 32'd3);
    check("b2b_gap1", 32'(pe[1] - pe[0]), 32'd5);
    check("b2b_gap2", 32'(pe[2] - pe[1]), 32'd5);
    check("b2b_idles", 32'(idles), 32'd3);
    check("b2b_rd", bus.read_data, 32'hDEAD78EF);

    // Address wrap: upper bits ignored.
    run_req("st_wrap", 1'b1, 2'b10, 1'b0, 32'h000001FC, 32'h0BADCAFE, rd, mis);
    run_req("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h000000FC, 32'h0, rd, mis);
    check("ld_wrap", rd, 32'h0BADCAFE);
    run_req("ld_wrap_b", 1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0, rd, mis);
    check("ld_wrap_b", rd, 32'h0000000B);

    // Reset during WAIT aborts a store.
    run_req("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, mis);
    run_req("ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis);
    check("ld_w20", rd, 32'h11223344);
    @(negedge clk);
    bus.mem_req = 1'b1;
    bus.mem_wr = 1'b1;
    bus.size = 2'b10;
    bus.addr = 32'h20;
    bus.write_data = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_ready", 32'(bus.mem_ready), 32'h0);
    check("abort_rd", bus.read_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("ld_w20_abort", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis);
    check("ld_w20_abort", rd, 32'h11223344);

    // Misaligned accesses.
    run_req("st_w22", 1'b1, 2'b10, 1'b0, 32'h22, 32'hA1B2C3D4, rd, mis);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("st_w22_mis", 32'(mis), 32'h1);
`else
    check("st_w22_mis", 32'(mis), 32'h0);
`endif
    check("mis_cleared", 32'(bus.misalign), 32'h0);
    run_req("ld_w20_mis", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("ld_w20_mis", rd, 32'h11223344);
`else
    check("ld_w20_mis", rd, 32'hA1B2C3D4);
`endif
    run_req("ld_h21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, rd, mis);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("ld_h21", rd, 32'h0);
    check("ld_h21_mis", 32'(mis), 32'h1);
`else
    check("ld_h21", rd, 32'hFFFFC3D4);
    check("ld_h21_mis", 32'(mis), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Multi-cycle data-memory stage of the CPU; sits directly downstream of the B data register.
- Accepts one load or store per request from the control FSM. Takes the registered rs2 value as store data and the ALU-result register as address.
- Models a configurable wait-state memory and returns extended load data for the data-return register plus a one-cycle ready pulse.
- Supports byte, halfword and word accesses, little-endian.

Parameters:
- DEPTH_BYTES, 256, memory size in bytes; power of two, minimum 4.
- LATENCY, 2, wait states between request acceptance and the access edge; 0 to 15.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- mem_req  in  1  request strobe; sampled only in IDLE.
- mem_wr  in  1  1 = store, 0 = load; captured with mem_req.
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word; captured with mem_req.
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- addr  in  32  byte address; only the low log2(DEPTH_BYTES) bits are used, upper bits wrap.
- write_data  in  32  store data from the B data register; byte/half use the low bits.
- read_data  out  32  extended load result, registered.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- misalign  out  1  alignment fault flag, valid with mem_ready.

Behaviour:
- Reset (asynchronous, Reset=0):
  - state=IDLE; read_data=0; mem_ready=0; misalign=0; busy=0; wait counter=0.
  - Memory array is not cleared.
  - Reset mid-operation aborts the access; a pending store is never written.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with mem_req=1: capture mem_wr, size, load_unsigned, addr, write_data; load counter=LATENCY; go to WAIT.
  - mem_req=0: stay in IDLE.
- WAIT:
  - counter!=0: decrement.
  - counter==0: perform the access on this edge and go to DONE.
  - mem_req is ignored in WAIT and DONE; no queueing.
- DONE:
  - mem_ready=1 for exactly this one cycle, then go to IDLE.
  - A new request is accepted no earlier than the edge that ends DONE+1, i.e. in the next IDLE cycle.
- Latency and throughput:
  - mem_ready rises LATENCY+1 edges after the edge that sampled mem_req.
  - Back-to-back requests therefore run at LATENCY+3 cycles each.
- Store at the access edge:
  - byte writes mem[a] = wd[7:0].
  - half writes mem[a] = wd[7:0] and mem[a+1] = wd[15:8].
  - word writes mem[a..a+3] = wd[7:0], wd[15:8], wd[23:16], wd[31:24].
  - read_data is unchanged by a store.
- Load at the access edge: read_data receives the assembled value, little-endian.
  - Byte/half: bits above the width are replicated from the MSB when load_unsigned=0, zero when load_unsigned=1.
  - Word: taken as-is.
- Address wrap: a is addr mod DEPTH_BYTES; a word at DEPTH_BYTES-4 is the last legal word.
- size=11 behaves exactly like word.
- misalign is registered at the access edge and cleared on leaving DONE.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Half with a[0]=1, or word with a[1:0]!=0, sets misalign=1 in DONE.
  - The store is suppressed and read_data is forced to 0.
  - Timing is unchanged.
- Undefined:
  - misalign is tied to 0.
  - Low address bits are forced to alignment: half clears a[0], word clears a[1:0]; the access proceeds.

Test Plan:
- Reset release then word store: addr=0x10, wd=0xDEADBEEF, mem_wr=1, LATENCY=2 -> mem_ready pulses 3 edges after request; word load of 0x10 returns 0xDEADBEEF.
- Byte loads from the same word: addr=0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Half load from 0x10 signed -> 0xFFFFBEEF.
- Byte store: wd=0x12345678 to addr=0x11 over 0xDEADBEEF -> word load of 0x10 returns 0xDEAD78EF.
- Request held high continuously for 3 requests -> exactly 3 mem_ready pulses, 5 cycles apart (LATENCY=2); busy low only in the IDLE cycles.
- Reset asserted during WAIT of a store of 0xCAFEF00D to 0x20 -> outputs 0 immediately; after release a word load of 0x20 returns the prior contents.
- Word store to addr=0x22 with macro defined -> misalign=1 with mem_ready and memory unchanged. Without the macro -> data lands at 0x20, misalign=0.
